// File: rtl/nn_pkg.sv
// Shared constants for the neuron datapath: adder-tree sum format and
// default requantization parameters.
package nn_pkg;

  localparam int SUM_W         = 21;
  localparam int SUM_SIGN_BIT  = 20;
  localparam int SUM_MAG_MSB   = 19;
  localparam int SUM_MAG_W     = 20;
  localparam int DEFAULT_SHIFT = 7;
  localparam int DEFAULT_OUT_W = 8;
  localparam int SAT_CNT_W     = 16;

  typedef struct packed {
    logic                 sign;
    logic [SUM_MAG_W-1:0] mag;
  } sum_t;

endpackage

// File: rtl/sm_round_sat.sv
// Combinational rounding (round-half-up on magnitude) and saturation to a
// sign-magnitude output. Optional ReLU via SUM_REQUANTIZER_RELU_EN.
module sm_round_sat
  import nn_pkg::*;
#(
  parameter int SHIFT = DEFAULT_SHIFT,
  parameter int OUT_W = DEFAULT_OUT_W
) (
  input  logic [SUM_MAG_W-1:0] i_mag,
  output logic [SUM_MAG_W-1:0] o_mag_r,
  input  logic                 i_sign,
  input  logic [SUM_MAG_W-1:0] i_mag_r,
  output logic [OUT_W-1:0]     o_q,
  output logic                 o_sat
);

  localparam logic [SUM_W-1:0]     ROUND_BIAS  = SUM_W'(1) << (SHIFT - 1);
  localparam logic [SUM_MAG_W-1:0] MAG_MAX     = SUM_MAG_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [OUT_W-2:0]     MAG_MAX_OUT = '1;

  logic [SUM_W-1:0] w_biased;
  logic             w_over;
  logic [OUT_W-2:0] w_mag_sat;

  // A zero-extended 21-bit sum cannot overflow: max is (2^20-1) + 2^(SHIFT-1).
  assign w_biased = {1'b0, i_mag} + ROUND_BIAS;
  assign o_mag_r  = SUM_MAG_W'(w_biased >> SHIFT);

  assign w_over    = (i_mag_r > MAG_MAX);
  assign w_mag_sat = w_over ? MAG_MAX_OUT : i_mag_r[OUT_W-2:0];

  always_comb begin
    o_q   = '0;
    o_sat = 1'b0;
`ifdef SUM_REQUANTIZER_RELU_EN
    if (i_sign && (w_mag_sat != '0)) begin
      o_q   = '0;
      o_sat = 1'b0;
    end else begin
      o_q   = {1'b0, w_mag_sat};
      o_sat = w_over;
    end
`else
    // Sign is dropped on a zero magnitude so negative zero never appears.
    o_q   = {i_sign && (w_mag_sat != '0), w_mag_sat};
    o_sat = w_over;
`endif
  end

endmodule

// File: rtl/sum_requantizer.sv
// Two-stage requantizer (S1 round/shift, S2 saturate/sign) with valid/ready
// handshake and saturation counter. Optional ReLU: SUM_REQUANTIZER_RELU_EN.
module sum_requantizer
  import nn_pkg::*;
#(
  parameter int SHIFT = DEFAULT_SHIFT,
  parameter int OUT_W = DEFAULT_OUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SUM_W-1:0]     sum_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     q_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SAT_CNT_W-1:0] sat_cnt,
  input  logic                 sat_clr
);

  sum_t                 w_sum;
  logic                 w_en;
  logic [SUM_MAG_W-1:0] w_mag_r;
  logic [OUT_W-1:0]     w_q;
  logic                 w_sat;

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic [SUM_MAG_W-1:0] r_s1_mag_r;
  logic                 r_s2_valid;
  logic [OUT_W-1:0]     r_q;
  logic                 r_sat;
  logic [SAT_CNT_W-1:0] r_sat_cnt;

  assign w_sum    = sum_in;
  assign w_en     = out_ready | ~r_s2_valid;
  assign in_ready = w_en;

  sm_round_sat #(
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .i_mag   (w_sum.mag),
    .o_mag_r (w_mag_r),
    .i_sign  (r_s1_sign),
    .i_mag_r (r_s1_mag_r),
    .o_q     (w_q),
    .o_sat   (w_sat)
  );

  // Both stages advance together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag_r <= '0;
      r_s2_valid <= 1'b0;
      r_q        <= '0;
      r_sat      <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= w_sum.sign;
      r_s1_mag_r <= w_mag_r;
      r_s2_valid <= r_s1_valid;
      r_q        <= w_q;
      r_sat      <= w_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (r_s2_valid && out_ready && r_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign q_out     = r_q;
  assign out_valid = r_s2_valid;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_sum_requantizer.sv
// Directed self-checking bench for sum_requantizer; expected values are
// hand-computed, with ReLU variants selected by SUM_REQUANTIZER_RELU_EN.
module tb_sum_requantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [20:0] sumIn;
  logic        inValid;
  logic        inReady;
  logic [7:0]  qOut;
  logic        outValid;
  logic        outReady;
  logic [15:0] satCnt;
  logic        satClr;

  int checkCount = 0;
  int failCount  = 0;
  int expSatCnt  = 0;

  sum_requantizer dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sumIn),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .q_out     (qOut),
    .out_valid (outValid),
    .out_ready (outReady),
    .sat_cnt   (satCnt),
    .sat_clr   (satClr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer: checks 2-cycle latency, value and counter update.
  task automatic applyStimulus(input string tag, input logic sign,
                               input logic [19:0] mag, input logic [7:0] expQ,
                               input int satInc);
    sumIn    = {sign, mag};
    inValid  = 1'b1;
    outReady = 1'b1;
    stepClk();
    inValid = 1'b0;
    checkOutput({tag, "_early_valid"}, outValid, 0);
    stepClk();
    checkOutput({tag, "_valid"}, outValid, 1);
    checkOutput({tag, "_q"}, qOut, expQ);
    stepClk();
    expSatCnt += satInc;
    checkOutput({tag, "_satcnt"}, satCnt, expSatCnt);
    checkOutput({tag, "_drained"}, outValid, 0);
  endtask

  initial begin
    int sent;
    int got;
    bit stall;

    rst      = 1'b1;
    sumIn    = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    satClr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_q_out", qOut, 0);
    checkOutput("reset_sat_cnt", satCnt, 0);
    checkOutput("reset_in_ready", inReady, 1);
    rst = 1'b0;
    stepClk();

    applyStimulus("pass", 1'b0, 20'd12800, 8'h64, 0);
`ifdef SUM_REQUANTIZER_RELU_EN
    applyStimulus("negsat", 1'b1, 20'hFFFFF, 8'h00, 0);
    applyStimulus("neg64", 1'b1, 20'd64, 8'h00, 0);
`else
    applyStimulus("negsat", 1'b1, 20'hFFFFF, 8'hFF, 1);
    applyStimulus("neg64", 1'b1, 20'd64, 8'h81, 0);
`endif
    applyStimulus("rnd64", 1'b0, 20'd64, 8'h01, 0);
    applyStimulus("rnd63", 1'b0, 20'd63, 8'h00, 0);
    applyStimulus("neg63", 1'b1, 20'd63, 8'h00, 0);
    applyStimulus("max127", 1'b0, 20'd16256, 8'h7F, 0);
    applyStimulus("over128", 1'b0, 20'd16320, 8'h7F, 1);

    // Back-pressure: values k*128 -> q = k, downstream stalls cycles 3..5.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 30; c++) begin
      stall    = (c >= 3) && (c <= 5);
      outReady = !stall;
      inValid  = (sent < 6);
      sumIn    = {1'b0, 20'((sent + 1) * 128)};
      #1;
      if (stall) checkOutput("bp_stall_in_ready", inReady, 0);
      else       checkOutput("bp_free_in_ready", inReady, 1);
      if (inValid && inReady) sent++;
      if (outValid && outReady) begin
        checkOutput("bp_order", qOut, got + 1);
        got++;
      end
      stepClk();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    checkOutput("bp_sent", sent, 6);
    checkOutput("bp_received", got, 6);

    // Counter saturation, then clear racing a saturating accept.
    sumIn   = {1'b0, 20'hFFFFF};
    inValid = 1'b1;
    repeat (65545) stepClk();
    checkOutput("cnt_saturated", satCnt, 16'hFFFF);
    satClr = 1'b1;
    stepClk();
    satClr  = 1'b0;
    inValid = 1'b0;
    checkOutput("cnt_clear_wins", satCnt, 0);
    repeat (2) stepClk();
    checkOutput("cnt_after_drain", satCnt, 2);

    // Async reset with two results in flight.
    sumIn   = {1'b0, 20'd12800};
    inValid = 1'b1;
    stepClk();
    sumIn = {1'b0, 20'd256};
    stepClk();
    inValid = 1'b0;
    checkOutput("ar_inflight_valid", outValid, 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("ar_out_valid", outValid, 0);
    checkOutput("ar_q_out", qOut, 0);
    checkOutput("ar_sat_cnt", satCnt, 0);
    @(posedge clk);
    outReady = 1'b0;
    #4;
    rst = 1'b0;
    #1;
    checkOutput("ar_in_ready", inReady, 1);
    outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stepClk();
      checkOutput("ar_no_stale", outValid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sum_requantizer.md
SUM_REQUANTIZER -- requirements
Module: sum_requantizer

Interface
REQ-001 Parameter SHIFT, default 7: right-shift that returns the sum magnitude to the neuron Q-format.
REQ-002 Parameter OUT_W, default 8: output width, sign-magnitude (1 sign bit + OUT_W-1 magnitude bits).
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port sum_in, input, 21: adder-tree result; bit 20 = sign, bits 19:0 = magnitude.
REQ-006 Port in_valid, input, 1: sum_in is valid this cycle.
REQ-007 Port in_ready, output, 1: block accepts sum_in this cycle.
REQ-008 Port q_out, output, OUT_W: requantized neuron value, sign-magnitude.
REQ-009 Port out_valid, output, 1: q_out is valid.
REQ-010 Port out_ready, input, 1: downstream accepts q_out.
REQ-011 Port sat_cnt, output, 16: count of saturated results.
REQ-012 Port sat_clr, input, 1: synchronous clear of sat_cnt.

Function
REQ-013 Transfers SHALL occur only on a cycle where valid and ready are both high, on both the input and output sides.
REQ-014 Pipeline SHALL have two register stages (S1: round/shift; S2: saturate/sign) with a common advance enable en = out_ready | ~out_valid.
REQ-015 in_ready SHALL equal en, combinationally.
REQ-016 Latency from input accept to out_valid SHALL be exactly 2 cycles when never stalled; full throughput is one result per cycle.
REQ-017 While en = 0, the S1 and S2 contents and q_out SHALL hold; no data SHALL be dropped or duplicated.
REQ-018 Bubbles (in_valid = 0 while en = 1) SHALL propagate as invalid stage entries.
REQ-019 S1 SHALL compute mag_r = (mag + 2^(SHIFT-1)) >> SHIFT, which is round-half-up on magnitude, i.e. symmetric about zero. The addition SHALL be 21 bits wide and SHALL NOT overflow.
REQ-020 S2 saturation rule:
- if mag_r > 2^(OUT_W-1)-1, the output magnitude SHALL be 2^(OUT_W-1)-1 and the result SHALL be flagged saturated;
- otherwise the output magnitude SHALL be mag_r.
REQ-021 If the final magnitude is 0, the output sign SHALL be 0, so negative zero is never emitted.
REQ-022 sat_cnt SHALL increment by 1 when a saturated result is accepted downstream (out_valid & out_ready).
REQ-023 sat_cnt SHALL saturate at 0xFFFF and not wrap.
REQ-024 When sat_clr and an increment coincide, sat_clr SHALL win and sat_cnt SHALL become 0.

Reset
REQ-025 When rst is asserted, out_valid, all stage-valid bits, q_out and sat_cnt SHALL go to 0 immediately, without waiting for a clock edge.
REQ-026 Reset asserted mid-operation SHALL discard in-flight data; the first cycle after deassertion SHALL have in_ready = 1.

Configuration
REQ-027 Macro SUM_REQUANTIZER_RELU_EN, when defined: any negative result with nonzero magnitude SHALL be emitted as 0, and such results SHALL NOT count as saturated.
REQ-028 When SUM_REQUANTIZER_RELU_EN is undefined, the sign SHALL pass through per REQ-021 and negative results SHALL saturate symmetrically.

Structure
REQ-029 Package nn_pkg SHALL hold:
- SUM_W = 21;
- the default SHIFT and OUT_W values;
- the sign-bit index constants shared with the adder tree.
REQ-030 Rounding and saturation SHALL be a combinational sub-module sm_round_sat, instantiated once; handshake, stage registers and counter SHALL live in sum_requantizer.

Verification
REQ-031 Pass-through: sum_in = {0, 20'd12800}, out_ready = 1 -> q_out = 8'h64 (mag 100) exactly 2 cycles after accept.
REQ-032 Rounding: magnitude 20'd64 -> mag 1; magnitude 20'd63 -> 0. Sign 1 with magnitude 63 -> q_out = 8'h00, never 8'h80.
REQ-033 Saturation: magnitude 20'hFFFFF with sign 1 -> q_out = 8'hFF and sat_cnt = 1. With SUM_REQUANTIZER_RELU_EN defined -> q_out = 8'h00 and sat_cnt = 0.
REQ-034 Back-pressure: stream 6 values with out_ready low for 3 cycles mid-stream -> all 6 outputs appear in order, none lost or duplicated, and in_ready is low during the stall.
REQ-035 Counter: force 65 540 saturating accepts -> sat_cnt = 0xFFFF. Then sat_clr together with a saturating accept -> sat_cnt = 0.
REQ-036 Async reset: assert rst between clock edges with two results in flight -> out_valid and q_out are 0 before the next edge, and no stale output appears after release.
